// File: rtl/disp_pkg.sv
// Shared constants, defaults and types for the multiplexed 4-digit display scanner.
package disp_pkg;

  localparam int N_DIG = 4;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [N_DIG-1:0] AN_OFF = 4'b1111;

  localparam int DIV_DEFAULT          = 100000;
  localparam int GUARD_DEFAULT        = 16;
  localparam int BLINK_FRAMES_DEFAULT = 125;

  // Per-frame snapshot of the display inputs; only this copy drives the outputs.
  typedef struct packed {
    logic [4*N_DIG-1:0] digits;
    logic [N_DIG-1:0]   blank;
    logic [N_DIG-1:0]   blink;
    logic [N_DIG-1:0]   dp;
  } shadow_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [N_DIG-1:0] an_sel(input logic [1:0] idx);
    return ~(N_DIG'(1) << idx);
  endfunction

endpackage

// File: rtl/disp_scan_if.sv
// Display-side signal bundle: digit/mask inputs toward the scanner, anode/data outputs back.
interface disp_scan_if;
  import disp_pkg::*;

  logic [4*N_DIG-1:0] digits;
  logic [N_DIG-1:0]   blank_mask;
  logic [N_DIG-1:0]   blink_mask;
  logic [N_DIG-1:0]   dp_in;
  logic [3:0]         data;
  logic [N_DIG-1:0]   an;
  logic               dp;
  logic               frame_tick;

  modport master (
    output digits, blank_mask, blink_mask, dp_in,
    input  data, an, dp, frame_tick
  );

  modport slave (
    input  digits, blank_mask, blink_mask, dp_in,
    output data, an, dp, frame_tick
  );

endinterface

// File: rtl/tick_div.sv
// Free-running 0..DIV-1 counter with a one-cycle pulse on its last count.
module tick_div #(
  parameter int DIV = 100000,
  localparam int CW = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          tick
);

  logic [CW-1:0] count_q, count_d;

  assign tick  = (count_q == CW'(DIV - 1));
  assign count = count_q;

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/disp_scan.sv
// Time-multiplexed 4-digit scanner: per-frame input snapshot, anti-ghost guard, blanking
// and blinking; emits BCD codes for an external 7-segment decoder.
module disp_scan
  import disp_pkg::*;
#(
  parameter int DIV          = DIV_DEFAULT,
  parameter int GUARD        = GUARD_DEFAULT,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  disp_scan_if.slave bus
);

  localparam int CW = $clog2(DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] cnt;
  logic          slot_tick;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .count (cnt),
    .tick  (slot_tick)
  );

  logic [1:0]       idx_q, idx_d;
  shadow_t          shadow_q, shadow_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic [N_DIG-1:0] an_q, an_d;
  logic [3:0]       data_q, data_d;
  logic             dp_q, dp_d;
  logic             frame_tick_q, frame_tick_d;

  logic             frame_start;
  logic             frame_end;
  logic [3:0]       nib [N_DIG];
  logic [N_DIG-1:0] dark;

  assign frame_start = (idx_q == 2'd0) && (cnt == '0);
  assign frame_end   = slot_tick && (idx_q == 2'(N_DIG - 1));

  // A nibble equal to the blank code is treated as dark so no anode is driven for it.
  for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
    assign nib[gi]  = shadow_q.digits[gi*4 +: 4];
    assign dark[gi] = shadow_q.blank[gi]
                    | (shadow_q.blink[gi] & blink_phase_q)
                    | (nib[gi] == BLANK_CODE);
  end

  always_comb begin
    idx_d         = slot_tick ? idx_q + 2'd1 : idx_q;
    shadow_d      = shadow_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    an_d          = AN_OFF;
    data_d        = BLANK_CODE;
    dp_d          = 1'b1;
    frame_tick_d  = frame_start;

    if (frame_start) begin
      shadow_d = '{digits: bus.digits, blank: bus.blank_mask,
                   blink: bus.blink_mask, dp: bus.dp_in};
    end

    // Counting completed frames keeps the post-reset frame in the first visible phase.
    if (frame_end) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    if ((cnt >= CW'(GUARD)) && !dark[idx_q]) begin
      an_d   = an_sel(idx_q);
      data_d = nib[idx_q];
      dp_d   = ~shadow_q.dp[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      shadow_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      an_q          <= AN_OFF;
      data_q        <= BLANK_CODE;
      dp_q          <= 1'b1;
      frame_tick_q  <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      an_q          <= an_d;
      data_q        <= data_d;
      dp_q          <= dp_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.data       = data_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_disp_scan.sv
// Scoreboard bench for disp_scan: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_disp_scan;
  import disp_pkg::*;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] data;
    logic       dp;
    logic       ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disp_scan_if bus ();

  disp_scan #(.DIV(DIV), .GUARD(GUARD), .BLINK_FRAMES(BF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       q[$];
  int         checks   = 0;
  int         failures = 0;
  int         k        = 0;
  int         cyc      = 0;
  logic [15:0] sh_dig  = '0;
  logic [3:0]  sh_blank = '0, sh_blink = '0, sh_dp = '0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, expv);
    end
  endtask

  // Expected outputs after the k-th edge since reset, from the snapshot taken at frame start.
  function automatic exp_t model(input int kk);
    exp_t e;
    int j, slot, c, f;
    logic phase;
    logic [3:0] nib;
    j     = kk % FRAME;
    slot  = j / DIV;
    c     = j % DIV;
    f     = kk / FRAME;
    phase = ((f / BF) % 2) == 1;
    nib   = sh_dig[slot*4 +: 4];
    e.ft  = (j == 0);
    e.an  = 4'hF;
    e.data = 4'hF;
    e.dp  = 1'b1;
    if (c >= GUARD && !sh_blank[slot] && !(sh_blink[slot] && phase) && nib != 4'hF) begin
      e.an   = ~(4'b0001 << slot);
      e.data = nib;
      e.dp   = ~sh_dp[slot];
    end
    return e;
  endfunction

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (k % FRAME == 0) begin
        sh_dig   = bus.digits;
        sh_blank = bus.blank_mask;
        sh_blink = bus.blink_mask;
        sh_dp    = bus.dp_in;
      end
      q.push_back(model(k));
      k++;
    end
  endtask

  // Entered at a falling edge; holds reset for n rising edges.
  task automatic do_reset(input int n);
    exp_t r;
    r = '{an: 4'hF, data: 4'hF, dp: 1'b1, ft: 1'b0};
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      q.push_back(r);
    end
    @(negedge clk);
    rst = 1'b0;
    k   = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      checks++;
      if (!(bus.an === 4'hF || $countones(~bus.an) == 1)) begin
        failures++;
        if (failures <= 30) $display("FAIL an_onehot cycle=%0d actual=%b required=1111_or_one_low", cyc, bus.an);
      end
      checks++;
      if (bus.data === 4'hF && bus.an !== 4'hF) begin
        failures++;
        if (failures <= 30) $display("FAIL blank_dark cycle=%0d actual_an=%b required=1111", cyc, bus.an);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check("an", bus.an, e.an);
        check("data", bus.data, e.data);
        check("dp", {3'b000, bus.dp}, {3'b000, e.dp});
        check("frame_tick", {3'b000, bus.frame_tick}, {3'b000, e.ft});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    bus.digits     = 16'h1234;
    bus.blank_mask = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.dp_in      = 4'b0100;

    // Basic scan: 4,3,2,1 with dp on digit 2, 32-cycle frames.
    do_reset(3);
    run_cycles(64);

    // Mid-frame digit change at idx=1 must wait for the next frame.
    run_cycles(12);
    @(negedge clk);
    bus.digits = 16'h5678;
    run_cycles(52);

    // Blank digit 3, non-BCD nibbles pass through.
    @(negedge clk);
    bus.digits     = 16'h9EA0;
    bus.blank_mask = 4'b1000;
    run_cycles(64);

    // Blink digit 0: visible frames 0-1, dark 2-3, visible 4-5.
    @(negedge clk);
    bus.digits     = 16'h1234;
    bus.blank_mask = 4'b0000;
    bus.blink_mask = 4'b0001;
    bus.dp_in      = 4'b0001;
    do_reset(2);
    run_cycles(6 * FRAME);

    // Reset pulse at cnt=5, idx=2 aborts the scan.
    @(negedge clk);
    bus.blink_mask = 4'b0000;
    bus.dp_in      = 4'b0100;
    do_reset(1);
    run_cycles(2 * DIV + 5);
    @(negedge clk);
    do_reset(1);
    run_cycles(2 * FRAME);

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Parameters
REQ-001 SHALL provide DIV, default 100000, clock cycles per digit slot (1 ms at 100 MHz); legal range 4..2^20.
REQ-002 SHALL provide GUARD, default 16, anti-ghost cycles at the start of each slot with all anodes off; legal 2 <= GUARD < DIV.
REQ-003 SHALL provide BLINK_FRAMES, default 125, full scan frames per blink-phase toggle (0.5 s per phase at defaults); legal >= 1.

Interface
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 digits  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3.
REQ-007 blank_mask  in  4  bit i=1 forces digit i dark.
REQ-008 blink_mask  in  4  bit i=1 makes digit i dark while blink phase = 1.
REQ-009 dp_in  in  4  bit i=1 lights the decimal point of digit i (colon/separator).
REQ-010 data  out  4  BCD code for the downstream 7-segment decoder; 4'hF = all segments off.
REQ-011 an  out  4  digit anodes, active-low, at most one bit low.
REQ-012 dp  out  1  decimal point, active-low.
REQ-013 frame_tick  out  1  one-cycle pulse at each frame start.

Function
REQ-014 slot counter cnt SHALL count 0..DIV-1 and wrap; digit index idx (2 bits) SHALL increment mod 4 on the cycle cnt = DIV-1.
REQ-015 frame start SHALL be the cycle with idx = 0 and cnt = 0; that cycle SHALL load shadow register from digits, blank_mask, blink_mask, dp_in. Inputs SHALL NOT affect outputs at any other time (no mid-frame tearing).
REQ-016 frame_tick SHALL assert in the cycle after each frame start, for exactly one cycle.
REQ-017 a blink frame counter SHALL count frame starts 0..BLINK_FRAMES-1; blink_phase SHALL toggle when it wraps.
REQ-018 digit idx is dark if shadow blank bit is set, or if shadow blink bit is set and blink_phase = 1.
REQ-019 all outputs SHALL be registered, one cycle latency from cnt/idx/shadow state.
REQ-020 when cnt < GUARD or the digit is dark: an = 4'b1111, data = 4'hF, dp = 1.
REQ-021 otherwise: an = ~(1 << idx), data = shadow nibble idx, dp = ~shadow dp bit idx.
REQ-022 non-BCD nibbles (A..E) SHALL pass through unchanged; the decoder blanks them.
REQ-023 full frame period SHALL be exactly 4*DIV cycles; no cycle is lost at wrap.

Reset
REQ-024 while rst = 1: cnt = 0, idx = 0, blink counter = 0, blink_phase = 0, shadow = all zeros, an = 4'b1111, data = 4'hF, dp = 1, frame_tick = 0.
REQ-025 the first cycle after rst deasserts SHALL be a frame start (shadow loads then).
REQ-026 rst asserted mid-slot or mid-frame SHALL abort the scan and apply REQ-024 on the next edge; no partial-slot outputs remain.

Structure
REQ-027 a shared package disp_pkg SHALL hold N_DIG = 4, BLANK_CODE = 4'hF, AN_OFF = 4'b1111 and the parameter defaults.
REQ-028 the slot counter with its wrap pulse SHALL be a sub-module tick_div (parameter DIV, outputs count and tick); the remainder stays flat.
REQ-029 data SHALL connect directly to the existing BCD-to-7-segment decoder; disp_scan contains no segment decoding.

Verification (DIV = 8, GUARD = 2, BLINK_FRAMES = 2)
REQ-030 digits = 16'h1234, masks 0, dp_in = 4'b0100 -> per frame an cycles 1110, 1101, 1011, 0111 for 6 cycles each after 2 cycles at 1111; data 4, 3, 2, 1; dp = 0 only in digit-2 slot; frame period = 32 cycles.
REQ-031 digits changes 16'h1234 -> 16'h5678 at idx = 1 mid-frame -> rest of that frame shows 3, 2, 1; next frame shows 8, 7, 6, 5.
REQ-032 blank_mask = 4'b1000 -> slot 3 keeps an = 1111, data = F every frame; other slots unaffected.
REQ-033 blink_mask = 4'b0001 -> digit 0 visible in frames 0-1, dark in frames 2-3, visible in frames 4-5; frame_tick one pulse per 32 cycles.
REQ-034 rst pulsed for 1 cycle at cnt = 5, idx = 2 -> next cycle all outputs at reset values; first frame_tick 1 cycle after rst low, then every 32 cycles.
REQ-035 every cycle of every test: an is never other than 1111 or exactly one 0; an = 1111 whenever data = F.
